uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 138 +++++++++++++
 tb/tb_uart_tx_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: 8N1-style frame serializer driven by an external oversampling tick,
// with optional parity bit and configurable stop length.
module uart_tx_engine #(
   parameter int D_W        = 8,
   parameter int B_TICK     = 16,
   parameter int STOP_TICKS = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tick,
   input  logic           tx_start,
   input  logic [D_W-1:0] din,
   output logic           txd,
   output logic           tx_busy,
   output logic           tx_done
);

   localparam int S_MAX = (B_TICK > STOP_TICKS) ? B_TICK : STOP_TICKS;
   localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
   localparam int N_W   = (D_W > 1) ? $clog2(D_W) : 1;

   localparam logic [S_W-1:0] BIT_LAST  = S_W'(B_TICK - 1);
   localparam logic [S_W-1:0] STOP_LAST = S_W'(STOP_TICKS - 1);
   localparam logic [N_W-1:0] DATA_LAST = N_W'(D_W - 1);
   localparam logic           HAS_PAR   = (PARITY_EN != 0);
   localparam logic           ODD_INV   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t         state;
   logic [S_W-1:0] s_cnt;
   logic [N_W-1:0] n_cnt;
   logic [D_W-1:0] shift;
   logic [D_W-1:0] shift_nxt;
   logic           par_bit;

   assign shift_nxt = shift >> 1;

   // NOTE: the shift register and parity bit carry no reset; they are always
   // reloaded on acceptance before being driven onto the line.
   always_ff @(posedge clk) begin
      if (state == IDLE && tx_start) begin
         shift   <= din;
         par_bit <= (^din) ^ ODD_INV;
      end else if (state == DATA && tick && s_cnt == BIT_LAST) begin
         shift <= shift_nxt;
      end
   end

   // NOTE: all state uses non-blocking assignment so every register sees the
   // pre-edge values of its neighbours, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         s_cnt   <= '0;
         n_cnt   <= '0;
         txd     <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  s_cnt   <= '0;
                  state   <= START;
                  tx_busy <= 1'b1;
                  txd     <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt <= '0;
                     n_cnt <= '0;
                     state <= DATA;
                     txd   <= shift[0];
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt <= '0;
                     if (n_cnt == DATA_LAST) begin
                        if (HAS_PAR) begin
                           state <= PARITY;
                           txd   <= par_bit;
                        end else begin
                           state <= STOP;
                           txd   <= 1'b1;
                        end
                     end else begin
                        n_cnt <= n_cnt + 1'b1;
                        txd   <= shift_nxt[0];
                     end
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt <= '0;
                     state <= STOP;
                     txd   <= 1'b1;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               // Returning to IDLE here lets a start request in the tx_done cycle chain frames.
               if (tick) begin
                  if (s_cnt == STOP_LAST) begin
                     s_cnt   <= '0;
                     state   <= IDLE;
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four configurations share one clock and baud tick; frames are
// decoded at bit centres and compared against expectations queued when each start is driven.
module tb_uart_tx_engine;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       par;
   } exp_t;

   logic       clk     = 1'b0;
   logic       tick    = 1'b0;
   logic       tick_en = 1'b1;
   int         div     = 0;
   int         tick_cnt = 0;
   int         clk_cnt  = 0;
   logic       rst      [4];
   logic       tx_start [4];
   logic [7:0] din      [4];
   logic       txd      [4];
   logic       tx_busy  [4];
   logic       tx_done  [4];
   exp_t       exp_q [$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      clk_cnt <= clk_cnt + 1;
      if (tick) tick_cnt <= tick_cnt + 1;
   end

   // One tick every 4 clocks; tick_en low freezes the divider so the phase survives a stall.
   always @(posedge clk) begin
      #1;
      if (tick_en) div = (div == 3) ? 0 : div + 1;
      tick = tick_en && (div == 3);
   end

   uart_tx_engine #(.D_W(8), .B_TICK(16), .STOP_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
      .clk(clk), .rst(rst[0]), .tick(tick), .tx_start(tx_start[0]), .din(din[0]),
      .txd(txd[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
   uart_tx_engine #(.D_W(8), .B_TICK(16), .STOP_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst(rst[1]), .tick(tick), .tx_start(tx_start[1]), .din(din[1]),
      .txd(txd[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
   uart_tx_engine #(.D_W(8), .B_TICK(16), .STOP_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst(rst[2]), .tick(tick), .tx_start(tx_start[2]), .din(din[2]),
      .txd(txd[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
   uart_tx_engine #(.D_W(8), .B_TICK(16), .STOP_TICKS(32), .PARITY_EN(0), .PARITY_ODD(0)) u_stop2 (
      .clk(clk), .rst(rst[3]), .tick(tick), .tx_start(tx_start[3]), .din(din[3]),
      .txd(txd[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

   task automatic push_exp(input int idx, input logic [7:0] data, input logic par);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      e.par  = par;
      exp_q.push_back(e);
   endtask

   task automatic wait_tick(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tick_cnt == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Start aligned to the tick phase; returns on the negedge after the accepting edge.
   task automatic start_frame(input int idx, input logic [7:0] data, input bit hold);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (div == 0) break;
      end
      din[idx]      = data;
      tx_start[idx] = 1'b1;
      @(negedge clk);
      if (!hold) tx_start[idx] = 1'b0;
   endtask

   task automatic capture(input int idx, input int par_en, input int stop_t, output int dur);
      exp_t       e;
      int         t0, c0, nb, total;
      bit         ok, found;
      logic [7:0] rx;
      logic       rp;
      dur   = 0;
      found = 1'b0;
      rx    = '0;
      rp    = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (txd[idx] === 1'b0) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL start_seen[%0d]: got txd=%b, expected 0 within 2000 clks", idx, txd[idx]);
         return;
      end
      t0    = tick_cnt;
      c0    = clk_cnt;
      nb    = 9 + par_en;
      total = 16 * nb + stop_t;
      for (int k = 0; k < nb; k++) begin
         wait_tick(t0 + 16 * k + 8, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL bit_timeout[%0d]: bit %0d, got tick_cnt=%0d, expected %0d", idx, k, tick_cnt, t0 + 16 * k + 8);
            return;
         end
         if (k == 0) begin
            checks++;
            if (txd[idx] !== 1'b0 || tx_busy[idx] !== 1'b1) begin
               errors++;
               $display("FAIL start_bit[%0d]: got txd=%b busy=%b, expected txd=0 busy=1", idx, txd[idx], tx_busy[idx]);
            end
         end else if (k <= 8) begin
            rx[k-1] = txd[idx];
         end else begin
            rp = txd[idx];
         end
      end
      wait_tick(t0 + 16 * nb + 8, ok);
      checks++;
      if (!ok || txd[idx] !== 1'b1) begin
         errors++;
         $display("FAIL stop_level[%0d]: got txd=%b ok=%0d, expected txd=1", idx, txd[idx], ok);
      end
      wait_tick(t0 + 16 * nb + stop_t - 1, ok);
      checks++;
      if (!ok || txd[idx] !== 1'b1 || tx_busy[idx] !== 1'b1 || tx_done[idx] !== 1'b0) begin
         errors++;
         $display("FAIL stop_hold[%0d]: got txd=%b busy=%b done=%b, expected 1 1 0", idx, txd[idx], tx_busy[idx], tx_done[idx]);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard[%0d]: got frame 0x%02h with no expectation queued", idx, rx);
      end else begin
         e = exp_q.pop_front();
         if (e.idx != idx || rx !== e.data) begin
            errors++;
            $display("FAIL data[%0d]: got 0x%02h on dut %0d, expected 0x%02h on dut %0d", idx, rx, idx, e.data, e.idx);
         end
         if (par_en != 0) begin
            checks++;
            if (rp !== e.par) begin
               errors++;
               $display("FAIL parity[%0d]: got %b, expected %b", idx, rp, e.par);
            end
         end
      end
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_done[idx] === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || tick_cnt - t0 != total || tx_busy[idx] !== 1'b0) begin
         errors++;
         $display("FAIL done_ticks[%0d]: got done=%0d after %0d ticks busy=%b, expected done after %0d ticks busy=0",
                  idx, found, tick_cnt - t0, tx_busy[idx], total);
      end
      dur = clk_cnt - c0;
      @(negedge clk);
      checks++;
      if (tx_done[idx] !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse[%0d]: got tx_done=%b one clk later, expected 0", idx, tx_done[idx]);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         rst[i]      = 1'b1;
         tx_start[i] = 1'b0;
         din[i]      = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (txd[i] !== 1'b1 || tx_busy[i] !== 1'b0 || tx_done[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got txd=%b busy=%b done=%b, expected 1 0 0", i, txd[i], tx_busy[i], tx_done[i]);
         end
         rst[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int d;
      push_exp(0, 8'h55, 1'b0);
      start_frame(0, 8'h55, 1'b0);
      capture(0, 0, 16, d);
      // First tick lands 3 clks after acceptance, so 160 ticks span 3 + 159*4 clks.
      checks++;
      if (d != 639) begin
         errors++;
         $display("FAIL frame_clks: got %0d clks to tx_done, expected 639", d);
      end
      push_exp(0, 8'h3C, 1'b0);
      start_frame(0, 8'h3C, 1'b0);
      capture(0, 0, 16, d);
   endtask

   task automatic test_parity();
      int d;
      push_exp(1, 8'h07, 1'b1);
      start_frame(1, 8'h07, 1'b0);
      capture(1, 1, 16, d);
      push_exp(2, 8'h07, 1'b0);
      start_frame(2, 8'h07, 1'b0);
      capture(2, 1, 16, d);
      push_exp(1, 8'hB6, 1'b1);
      start_frame(1, 8'hB6, 1'b0);
      capture(1, 1, 16, d);
      push_exp(2, 8'h00, 1'b1);
      start_frame(2, 8'h00, 1'b0);
      capture(2, 1, 16, d);
   endtask

   task automatic test_back_to_back();
      int d;
      push_exp(0, 8'hA3, 1'b0);
      start_frame(0, 8'hA3, 1'b1);
      fork
         begin
            capture(0, 0, 16, d);
            capture(0, 0, 16, d);
         end
         begin
            repeat (200) @(negedge clk);
            din[0] = 8'hFF;
            push_exp(0, 8'hFF, 1'b0);
            for (int i = 0; i < 1000; i++) begin
               @(negedge clk);
               if (tx_done[0] === 1'b1) break;
            end
            repeat (50) @(negedge clk);
            tx_start[0] = 1'b0;
         end
      join
      checks++;
      if (tx_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_extra: got tx_busy=%b after second frame, expected 0", tx_busy[0]);
      end
   endtask

   task automatic test_reset_mid();
      int  t0, d;
      bit  ok, saw_done;
      start_frame(0, 8'h00, 1'b0);
      t0 = tick_cnt;
      wait_tick(t0 + 16 * 4 + 8, ok);
      checks++;
      if (!ok || txd[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_pre[%0d]: got txd=%b ok=%0d in data bit 3, expected 0", 0, txd[0], ok);
      end
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      checks++;
      if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_line: got txd=%b busy=%b, expected 1 0", txd[0], tx_busy[0]);
      end
      saw_done = 1'b0;
      repeat (800) begin
         @(negedge clk);
         if (tx_done[0] === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_done: got tx_done=1 after abort, expected none");
      end
      rst[0]      = 1'b1;
      tx_start[0] = 1'b1;
      din[0]      = 8'hC3;
      @(negedge clk);
      rst[0]      = 1'b0;
      tx_start[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_priority: got txd=%b busy=%b, expected 1 0", txd[0], tx_busy[0]);
      end
      push_exp(0, 8'h81, 1'b0);
      start_frame(0, 8'h81, 1'b0);
      capture(0, 0, 16, d);
   endtask

   task automatic stall_start(input int ta);
      bit ok, steady;
      wait_tick(ta + 5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall_arm: got tick_cnt=%0d, expected %0d", tick_cnt, ta + 5);
         return;
      end
      tick_en = 1'b0;
      steady  = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (txd[3] !== 1'b0 || tx_busy[3] !== 1'b1) steady = 1'b0;
      end
      tick_en = 1'b1;
      checks++;
      if (!steady) begin
         errors++;
         $display("FAIL stall_txd: got txd/busy change during stall, expected txd=0 busy=1 throughout");
      end
   endtask

   task automatic test_stall();
      int d1, d2, ta;
      push_exp(3, 8'h5A, 1'b0);
      start_frame(3, 8'h5A, 1'b0);
      capture(3, 0, 32, d1);
      push_exp(3, 8'hE1, 1'b0);
      start_frame(3, 8'hE1, 1'b0);
      ta = tick_cnt;
      fork
         capture(3, 0, 32, d2);
         stall_start(ta);
      join
      checks++;
      if (d2 - d1 != 100) begin
         errors++;
         $display("FAIL stall_shift: got %0d extra clks (%0d vs %0d), expected 100", d2 - d1, d2, d1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_reset_mid();
      test_stall();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d frames outstanding, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
